// File: rtl/types.sv
// Shared core types: register addressing and the MEM/WB write-back record.
package types;

    localparam int NUM_REGS = 16;
    localparam int XLEN     = 32;

    typedef logic [$clog2(NUM_REGS)-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t         rd_addr;
        logic [XLEN-1:0]   rd_data;
    } wb_params_t;

endpackage

// File: rtl/scoreboard.sv
// Per-register in-flight counters, RAW pending detection and sticky overflow flag.
// Latency: counters update on the rising edge; pending/stall are combinational.
// Backpressure: none taken; hazard_stall is the backpressure offered to ID.
module scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        issue_valid,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
    input  logic [$clog2(NUM_REGS)-1:0] wb_rd,
    input  logic [$clog2(NUM_REGS)-1:0] rs1_addr,
    input  logic [$clog2(NUM_REGS)-1:0] rs2_addr,
    output logic                        hazard_stall,
    output logic                        sb_overflow
);

    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt     [NUM_REGS];
    logic [CNT_W-1:0] cnt_nxt [NUM_REGS];
    logic             ovf_set;

    // Slot 0 exists only to keep indexing simple; it stays at zero.
    always_comb begin
        cnt_nxt = cnt;
        ovf_set = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if ((issue_valid && issue_rd == ADDR_W'(r)) && !(wb_rd == ADDR_W'(r))) begin
                if (cnt[r] == CNT_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    cnt_nxt[r] = cnt[r] + CNT_ONE;
                end
            end else if ((wb_rd == ADDR_W'(r)) && !(issue_valid && issue_rd == ADDR_W'(r))
                         && cnt[r] != '0) begin
                cnt_nxt[r] = cnt[r] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            sb_overflow <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (ovf_set) begin
                sb_overflow <= 1'b1;
            end
        end
    end

    // A write-back landing this cycle retires one reservation before the compare.
    function automatic logic pending(input logic [ADDR_W-1:0] a);
        return (cnt[a] != '0) && !((wb_rd == a) && (cnt[a] == CNT_ONE));
    endfunction

    assign hazard_stall = pending(rs1_addr) | pending(rs2_addr);

endmodule

// File: rtl/regfile_sb.sv
// Architectural register file with write-back bypass and issue scoreboard.
// Latency: reads 0 cycles (bypass covers same-cycle WB); writes visible in array next cycle.
// Backpressure: hazard_stall tells ID to hold while a source is still in flight.
module regfile_sb
    import types::wb_params_t;
#(
    parameter int NUM_REGS = 16,
    parameter int XLEN     = 32,
    parameter int CNT_W    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  wb_params_t                  wb_params_in,
    input  logic                        issue_valid,
    input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
    input  logic [$clog2(NUM_REGS)-1:0] rs1_addr,
    input  logic [$clog2(NUM_REGS)-1:0] rs2_addr,
    output logic [XLEN-1:0]             rs1_data,
    output logic [XLEN-1:0]             rs2_data,
    output logic                        hazard_stall,
    output logic                        sb_overflow
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [XLEN-1:0]   regs [NUM_REGS];
    logic [ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]   wb_dat;

    assign wb_rd  = wb_params_in.rd_addr;
    assign wb_dat = wb_params_in.rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wb_rd != '0) begin
            regs[wb_rd] <= wb_dat;
        end
    end

    always_comb begin
        rs1_data = regs[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (rs1_addr == wb_rd) begin
            rs1_data = wb_dat;
        end
    end

    always_comb begin
        rs2_data = regs[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (rs2_addr == wb_rd) begin
            rs2_data = wb_dat;
        end
    end

    scoreboard #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .wb_rd        (wb_rd),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .hazard_stall (hazard_stall),
        .sb_overflow  (sb_overflow)
    );

endmodule
